fir_band_scheduler: RTL and testbench
=====================================

Name: fir_band_scheduler

Overview:
Time-shares one multiply-accumulate unit across NBANDS 31-tap band-pass FIR filters, e.g. the 500-1000 Hz band and its sibling bands, for a 32 kHz audio stream. It owns a 32-entry circular sample history and sequences the external coefficient ROMs through band_sel/index. For each input sample it runs all bands back-to-back and produces one registered output per band. It sits between the audio codec sample strobe and the per-band level/visualisation logic.

Parameters:
NBANDS, 4, number of bands serviced per sample; legal range 1..4.
ACC_W, 23, accumulator and per-band output width. 10b coeff × 8b sample × 31 taps needs 23 bits, so there is no overflow at the default.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ready  in  1  one-cycle strobe: new sample valid on x
x  in  8  signed input sample
band_sel  out  2  selects which band's coefficient ROM drives coeff
index  out  5  tap index to coefficient ROMs, 0..30
coeff  in  10  signed coefficient for (band_sel, index); combinational, valid same cycle
y_bus  out  NBANDS*ACC_W  signed band results; band b at bits [b*ACC_W +: ACC_W]
done  out  1  one-cycle pulse when all y_bus bands have been updated
busy  out  1  high while sequencing
overrun  out  1  sticky: ready arrived while busy

Behaviour:
- Clocking and reset: all state updates on posedge clock. When reset is high:
  - all 32 history entries and wptr are cleared to 0;
  - acc, y_bus, band_sel, index, done, busy and overrun are cleared to 0;
  - the FSM goes to IDLE.
  - Reset mid-RUN aborts the pass; y_bus keeps no partial result.
- FSM states: IDLE, RUN.
- IDLE:
  - If ready: buf[wptr] <= x; wptr <= wptr+1 (5-bit wrap); acc <= 0; band_sel <= 0; index <= 0; busy <= 1; go to RUN.
- RUN, once per cycle:
  - Sample read: sample = buf[(wptr-1-index) mod 32]. Index 0 reads the newest sample; the read is combinational.
  - Product: coeff × sample, signed, sign-extended to ACC_W.
  - If index < 30: acc <= acc + product; index++.
  - If index == 30:
    - y_bus[band_sel] <= acc + product; acc <= 0; index <= 0.
    - If band_sel == NBANDS-1: go to IDLE, busy <= 0, done <= 1 next cycle.
    - Otherwise band_sel++.
- done: high for exactly one cycle, otherwise 0.
- Latency: ready sampled in cycle T → RUN occupies T+1..T+31·NBANDS → done high in T+31·NBANDS+1 (T+125 at default). y_bus[b] updates at the end of its band's 31st RUN cycle. Other bands hold their previous values until rewritten.
- Outputs while idle: band_sel and index hold 0.
- ready while busy (RUN): sample is dropped (buffer and wptr unchanged), overrun <= 1 and stays set until reset. The in-progress pass is unaffected. The nominal ready spacing of several hundred cycles makes this an error condition only.
- ready coincident with done: accepted, since the FSM is already IDLE in that cycle.
- History: pre-reset samples are zero, so the first 30 outputs reflect a zero-padded history.

Test Plan:
- Reset: hold reset 3 cycles with ready pulsing → y_bus=0, done=0, busy=0, overrun=0, index=0 after release.
- Latency: bench ROM returns coeff=band_sel+1; one ready with x=1 at cycle T → busy high T+1..T+124, done pulse only at T+125, y_b=b+1 for b=0..3.
- Impulse response: bench ROM returns band0 = −5,−4,−4,−3,−1,3,10,… (500-1000 Hz set), other bands constant 1. Apply x=100 then 30 zeros → after k-th ready (k=0..30) y_0=100·coeff0[k], y_1..y_3=100; after the 32nd ready (zero) y_1=0 (wrap-around).
- Saturation-free extreme: coeff=−512 all bands, x=−128 for 31 readies → y_b=+2,031,616 exactly, no wrap.
- Overrun: pulse ready at T and again at T+40 with x=77 → overrun=1 at T+41, buffer unchanged (next pass ignores 77), done still at T+125.
- Reset mid-RUN: assert reset at T+60 → busy=0, y_bus=0 next cycle; next ready runs a clean pass.

Source files
------------

// File: rtl/fir_band_scheduler.sv
// Shares one MAC across NBANDS 31-tap FIR filters over a 32-entry sample history.
// Each accepted sample runs every band back-to-back and pulses done when y_bus is complete.
module fir_band_scheduler #(
  parameter int NBANDS = 4,
  parameter int ACC_W  = 23
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  logic [7:0]              x,
  output logic [1:0]              band_sel,
  output logic [4:0]              index,
  input  logic [9:0]              coeff,
  output logic [NBANDS*ACC_W-1:0] y_bus,
  output logic                    done,
  output logic                    busy,
  output logic                    overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                         state, state_nxt;
  logic [7:0]                     hist [32];
  logic [4:0]                     wptr, rd_addr;
  logic signed [17:0]             prod;
  logic signed [ACC_W-1:0]        acc, prod_ext, sum;
  logic                           last_tap, last_band;
  logic [NBANDS-1:0][ACC_W-1:0]   y_r;

  // wptr points one past the newest sample, so tap 0 reads wptr-1.
  assign rd_addr   = wptr - 5'd1 - index;
  assign prod      = $signed(coeff) * $signed(hist[rd_addr]);
  assign prod_ext  = ACC_W'(prod);
  assign sum       = acc + prod_ext;
  assign last_tap  = (index == 5'd30);
  assign last_band = (band_sel == 2'(NBANDS-1));
  assign y_bus     = y_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (ready) state_nxt = RUN;
      RUN:  if (last_tap && last_band) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      for (int i = 0; i < 32; i++) hist[i] <= '0;
      wptr     <= '0;
      acc      <= '0;
      y_r      <= '0;
      band_sel <= '0;
      index    <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (ready) begin
            hist[wptr] <= x;
            wptr       <= wptr + 5'd1;
            acc        <= '0;
            band_sel   <= '0;
            index      <= '0;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          // A sample arriving mid-pass is dropped; the pass itself carries on.
          if (ready) overrun <= 1'b1;
          if (!last_tap) begin
            acc   <= sum;
            index <= index + 5'd1;
          end else begin
            for (int b = 0; b < NBANDS; b++)
              if (band_sel == 2'(b)) y_r[b] <= sum;
            acc   <= '0;
            index <= '0;
            if (last_band) begin
              band_sel <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              band_sel <= band_sel + 2'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_band_scheduler.sv
// Randomized bench for fir_band_scheduler: a tap-sum reference over a sample history
// and a coefficient ROM model answering band_sel/index.
module tb_fir_band_scheduler;
  localparam int NB  = 4;
  localparam int AW  = 23;
  localparam int LAT = 31*NB + 1;

  logic             clock = 1'b0;
  logic             reset, ready;
  logic [7:0]       x;
  logic [1:0]       band_sel;
  logic [4:0]       index;
  logic [9:0]       coeff;
  logic [NB*AW-1:0] y_bus;
  logic             done, busy, overrun;

  int checks = 0;
  int errors = 0;
  int mode   = 0;
  int rnd_rom [4][31];
  int imp [31] = '{-5, -4, -4, -3, -1, 3, 10, 17, 22, 20, 10, -8, -30, -50, -60, -64,
                   -60, -50, -30, -8, 10, 20, 22, 17, 10, 3, -1, -3, -4, -4, -5};
  int hist [32];   // hist[0] is the newest accepted sample

  fir_band_scheduler #(.NBANDS(NB), .ACC_W(AW)) dut (
    .clock(clock), .reset(reset), .ready(ready), .x(x),
    .band_sel(band_sel), .index(index), .coeff(coeff),
    .y_bus(y_bus), .done(done), .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  function automatic int rom(int b, int k);
    if (k > 30) return 0;
    case (mode)
      0:       return b + 1;
      1:       return (b == 0) ? imp[k] : 1;
      2:       return -512;
      default: return rnd_rom[b][k];
    endcase
  endfunction

  always_comb coeff = 10'(rom(int'(band_sel), int'(index)));

  function automatic longint model_y(int b);
    longint s = 0;
    for (int k = 0; k < 31; k++) s += longint'(rom(b, k)) * longint'(hist[k]);
    return s;
  endfunction

  function automatic longint ysl(int b);
    return longint'($signed(y_bus[b*AW +: AW]));
  endfunction

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic push(input int s);
    for (int i = 31; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) hist[i] = 0;
  endtask

  task automatic send(input logic signed [7:0] s);
    ready = 1'b1; x = s;
    tick();
    ready = 1'b0;
    push(int'(s));
  endtask

  // c0 is the cycle count (relative to the ready cycle) at which we are now.
  task automatic wait_done(input int c0, input string tag);
    int c = c0;
    while (!done && c < LAT + 50) begin tick(); c++; end
    chk(tag, c, LAT);
  endtask

  task automatic check_y(input string tag);
    for (int b = 0; b < NB; b++) chk(tag, ysl(b), model_y(b));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ready = (i % 2 == 0); x = 8'($urandom);
      tick();
    end
    reset = 1'b0; ready = 1'b0;
    clear_model();
  endtask

  initial begin
    reset = 1'b0; ready = 1'b0; x = '0;
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < 31; k++) rnd_rom[b][k] = $urandom_range(0, 1023) - 512;
    clear_model();

    // reset state
    do_reset();
    for (int b = 0; b < NB; b++) chk("rst_y", ysl(b), 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_idx", index, 0);
    chk("rst_band", band_sel, 0);

    // latency with coeff = band+1, x = 1
    mode = 0;
    send(8'sd1);
    for (int c = 1; c <= LAT; c++) begin
      chk("lat_busy", busy, (c <= LAT - 1) ? 1 : 0);
      chk("lat_done", done, (c == LAT) ? 1 : 0);
      if (c < LAT) tick();
    end
    check_y("lat_y_model");
    for (int b = 0; b < NB; b++) chk("lat_y_const", ysl(b), b + 1);
    tick();
    chk("lat_done_low", done, 0);
    chk("idle_idx", index, 0);
    chk("idle_band", band_sel, 0);

    // impulse response and history wrap-around
    do_reset();
    mode = 1;
    for (int k = 0; k < 31; k++) begin
      send((k == 0) ? 8'sd100 : 8'sd0);
      wait_done(1, "imp_lat");
      check_y("imp_y_model");
      chk("imp_y0", ysl(0), 100 * imp[k]);
      chk("imp_y1", ysl(1), 100);
      repeat ($urandom_range(0, 2)) tick();
    end
    send(8'sd0);
    wait_done(1, "imp_lat32");
    chk("imp_wrap_y1", ysl(1), 0);

    // extreme magnitude, no wrap
    mode = 2;
    for (int k = 0; k < 31; k++) begin
      send(-8'sd128);
      wait_done(1, "ext_lat");
    end
    for (int b = 0; b < NB; b++) chk("ext_y", ysl(b), 2031616);
    check_y("ext_y_model");

    // overrun: second ready mid-pass is dropped
    do_reset();
    mode = 3;
    send(8'($urandom));
    repeat (39) tick();
    ready = 1'b1; x = 8'd77;
    tick();
    ready = 1'b0;
    chk("ovr_flag", overrun, 1);
    wait_done(41, "ovr_lat");
    check_y("ovr_y");
    send(8'($urandom));
    wait_done(1, "ovr_next_lat");
    check_y("ovr_next_y");
    chk("ovr_sticky", overrun, 1);

    // reset mid-pass
    send(8'($urandom));
    repeat (59) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_model();
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_ovr", overrun, 0);
    for (int b = 0; b < NB; b++) chk("mid_y", ysl(b), 0);
    send(8'($urandom));
    wait_done(1, "mid_next_lat");
    check_y("mid_next_y");

    // random sweep; gap 0 exercises ready coincident with done
    for (int n = 0; n < 40; n++) begin
      send(8'($urandom));
      wait_done(1, "rnd_lat");
      check_y("rnd_y");
      repeat ($urandom_range(0, 3)) tick();
    end
    chk("rnd_no_ovr", overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
